swd_rsp_capture: RTL
====================

Name: swd_rsp_capture

Overview:
- Downstream consumer of the discrete SWD frontend's MISO line, clocked by the same SCK.
- Tracks the frontend's fixed bit timing and deserialises the target response: the 3-bit ACK, the 32-bit read data and the parity bit.
- Checks parity and presents frame status to the host-side logic in the ZYNQ PL.
- One frame is captured per release of rst_n, mirroring the frontend's frame/RAW model.

Parameters:
- DATA_W, 32, read data width (bits).
- ACK_BIT, 11, bit index of the first ACK bit.
- RD_BIT, 14, bit index of the first read data bit (parity at RD_BIT+DATA_W).
- WR_LAST, 47, bit index of the host write parity bit (last bit of a write frame).

Ports:
- sck  input  1  clock; everything samples on posedge sck.
- rst_n  input  1  synchronous active-low reset; 0 = RAW/idle, 1 = frame in progress.
- rnw  input  1  1 = READ frame, 0 = WRITE frame; latched at bit 0.
- miso  input  1  SWDIO readback from the frontend.
- ack  output  3  captured ACK, {bit13, bit12, bit11}; 001 = OK, 010 = WAIT, 100 = FAULT.
- ack_valid  output  1  high from the cycle after bit 13 until reset.
- rdata  output  DATA_W  read data, LSB-first assembled.
- rdata_valid  output  1  high after a READ with ACK = 001 completes; held until reset.
- parity_err  output  1  computed even parity != received parity bit; valid with rdata_valid.
- no_resp  output  1  ACK == 111 (line floating high); held until reset.
- frame_done  output  1  level; frame finished, held until reset.
- bit_idx  output  6  index of the next bit to be sampled; saturates in DONE.

Behaviour:
- **Reset:** rst_n = 0 at posedge clears all outputs and registers to 0, state = HDR. Asserting rst_n mid-frame aborts at the next posedge with no partial flags.
- **Bit counter:** bit_idx increments on each posedge while not in DONE. A frame's bit 0 is the first posedge with rst_n = 1. rnw is latched at bit 0 into rnw_q.
- **HDR (bits 0..ACK_BIT-1):** miso ignored.
- **ACK (bits 11..13):** shift register ack <= {miso, ack[2:1]}, so bit 11 lands in ack[0]. ack_valid sets on the posedge after bit 13 is sampled, i.e. when bit_idx becomes 14.
- **DECIDE (combinational at end of bit 13):**
  - ack != 001: go to DONE; frame_done = 1; no_resp = (ack == 111).
  - ack == 001 and rnw_q = 1: go to RDATA.
  - ack == 001 and rnw_q = 0: go to WSKIP.
- **RDATA (bits 14..45):** rdata <= {miso, rdata[DATA_W-1:1]}; running par ^= miso.
- **RPAR (bit 46):** parity_err <= par ^ miso; rdata_valid = 1; frame_done = 1; go to DONE.
- **WSKIP (bits 14..47):** miso ignored (host-driven). At bit WR_LAST, frame_done = 1; go to DONE.
- **DONE:**
  - All outputs hold; bit_idx frozen.
  - Further sck edges have no effect until rst_n = 0.
- **Output latency:** rdata/parity_err/rdata_valid update on the same posedge that samples parity (bit 46); all outputs are registered.
- **Output rules:**
  - rdata stays 0 on any non-READ-OK frame.
  - parity_err is 0 unless rdata_valid = 1.
- **rnw changes after bit 0:** ignored.
- **State encoding:** HDR, ACK, RDATA, RPAR, WSKIP, DONE. An illegal state recovers to DONE with frame_done = 1.

Test Plan:
- READ OK: rnw = 1, ACK bits 1,0,0, data 0x12345678 LSB-first, parity 1 -> ack = 001, rdata = 0x12345678, parity_err = 0, rdata_valid = 1 and frame_done = 1 after bit 46, bit_idx = 47.
- READ parity error: rnw = 1, ACK OK, data 0xFFFFFFFF, parity 1 -> rdata = 0xFFFFFFFF, parity_err = 1.
- WAIT: rnw = 1, ACK bits 0,1,0 -> ack = 010, frame_done = 1 at bit_idx 14, rdata_valid = 0, rdata = 0, subsequent 40 edges produce no change.
- WRITE OK: rnw = 0, ACK 001, miso toggling on bits 14..47 -> frame_done = 1 after bit 47, rdata = 0, rdata_valid = 0, parity_err = 0.
- No response: miso held 1 throughout -> ack = 111, no_resp = 1, frame_done = 1 at bit_idx 14.
- Mid-frame reset: READ OK, rst_n = 0 at bit 30, then a fresh READ with data 0xA5A5A5A5 and parity 0 -> all outputs 0 during reset, second frame yields rdata = 0xA5A5A5A5, parity_err = 0.

Source files
------------

// File: rtl/swd_rsp_capture.sv
// SWD response deserialiser: follows the frontend's fixed frame timing on sck,
// captures ACK, read data and parity, and reports per-frame status until reset.
module swd_rsp_capture #(
    parameter int DATA_W  = 32,
    parameter int ACK_BIT = 11,
    parameter int RD_BIT  = 14,
    parameter int WR_LAST = 47
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              rnw,
    input  logic              miso,
    output logic [2:0]        ack,
    output logic              ack_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              parity_err,
    output logic              no_resp,
    output logic              frame_done,
    output logic [5:0]        bit_idx
);

    // state  | meaning
    // HDR    | request header going out, miso ignored, rnw latched at bit 0
    // ACK    | shifting in the 3 ACK bits, decision on the last one
    // RDATA  | shifting in read data LSB-first, running parity
    // RPAR   | sampling the read parity bit, publishing read results
    // WSKIP  | host drives write data, waiting for the write parity bit
    // DONE   | frame finished, everything frozen until reset
    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_ACK   = 3'd1,
        S_RDATA = 3'd2,
        S_RPAR  = 3'd3,
        S_WSKIP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [5:0] HDR_LAST = 6'(ACK_BIT - 1);
    localparam logic [5:0] ACK_LAST = 6'(ACK_BIT + 2);
    localparam logic [5:0] RD_LAST  = 6'(RD_BIT + DATA_W - 1);
    localparam logic [5:0] WR_END   = 6'(WR_LAST);

    state_t     state;
    logic       rnw_q;
    logic       par;
    logic [2:0] ack_nxt;

    // ACK value including the bit being sampled now, used for the decision
    assign ack_nxt = {miso, ack[2:1]};

    always_ff @(posedge sck) begin
        if (!rst_n) begin
            state       <= S_HDR;
            rnw_q       <= 1'b0;
            par         <= 1'b0;
            ack         <= 3'b000;
            ack_valid   <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            parity_err  <= 1'b0;
            no_resp     <= 1'b0;
            frame_done  <= 1'b0;
            bit_idx     <= 6'd0;
        end else begin
            if (state != S_DONE) begin
                bit_idx <= bit_idx + 6'd1;
            end
            case (state)
                S_HDR: begin
                    if (bit_idx == 6'd0) begin
                        rnw_q <= rnw;
                    end
                    if (bit_idx == HDR_LAST) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack <= ack_nxt;
                    if (bit_idx == ACK_LAST) begin
                        ack_valid <= 1'b1;
                        if (ack_nxt != 3'b001) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                            no_resp    <= (ack_nxt == 3'b111);
                        end else if (rnw_q) begin
                            state <= S_RDATA;
                        end else begin
                            state <= S_WSKIP;
                        end
                    end
                end
                S_RDATA: begin
                    rdata <= {miso, rdata[DATA_W-1:1]};
                    par   <= par ^ miso;
                    if (bit_idx == RD_LAST) begin
                        state <= S_RPAR;
                    end
                end
                S_RPAR: begin
                    parity_err  <= par ^ miso;
                    rdata_valid <= 1'b1;
                    frame_done  <= 1'b1;
                    state       <= S_DONE;
                end
                S_WSKIP: begin
                    if (bit_idx == WR_END) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    frame_done <= 1'b1;
                    state      <= S_DONE;
                end
            endcase
        end
    end

endmodule
